// File: rtl/sha512_ctx_sched.sv
// Round scheduler for the two-context SHA-512 datapath: two threads own alternate cycles,
// each sequencing context load, ROUNDS rounds and result drain.
module sha512_ctx_sched #(
  parameter int unsigned ROUNDS     = 80,
  parameter int unsigned LOAD_WORDS = 8
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] ack,
  output logic [1:0] ready,
  output logic       tid,
  output logic       glbl_en,
  output logic       block2ctx_en,
  output logic [2:0] ld_addr,
  output logic       T1_rst,
  output logic       S1_CH_rst,
  output logic       S0_rst,
  output logic       S1_CH_en,
  output logic       S0_en,
  output logic       D2E_en,
  output logic       D2E_en2,
  output logic [6:0] rnd,
  output logic       out_en,
  output logic [2:0] out_addr,
  output logic [1:0] done
);

  typedef enum logic [1:0] {StIdle, StLoad, StRound, StDrain} state_e;

  typedef struct packed {
    logic       b2c;
    logic [2:0] ld_addr;
    logic       t1_rst;
    logic       s1_rst;
    logic       s0_rst;
    logic       s1_en;
    logic       s0_en;
    logic       d2e;
    logic       d2e2;
    logic [6:0] rnd;
    logic       out_en;
    logic [2:0] out_addr;
  } strb_t;

  localparam logic [6:0] LastLoad  = 7'(LOAD_WORDS - 1);
  localparam logic [6:0] LastRound = 7'(ROUNDS - 1);

  state_e     r_st0, r_st1;
  logic [6:0] r_cnt0, r_cnt1;
  logic       r_tid;
  logic [1:0] r_ack, r_done;
  strb_t      r_strb;

  state_e     w_cur_st, w_nxt_st, w_oth_st;
  logic [6:0] w_cur_cnt, w_nxt_cnt, w_oth_cnt;
  logic       w_cur_req, w_acc, w_fin;
  strb_t      w_strb;

  // Next-state for the thread that owns the current cycle; the other thread holds.
  always_comb begin
    w_cur_st  = r_tid ? r_st1 : r_st0;
    w_cur_cnt = r_tid ? r_cnt1 : r_cnt0;
    w_cur_req = req[r_tid];
    w_nxt_st  = w_cur_st;
    w_nxt_cnt = w_cur_cnt + 7'd1;
    w_acc     = 1'b0;
    w_fin     = 1'b0;
    unique case (w_cur_st)
      StIdle: begin
        w_nxt_cnt = '0;
        if (w_cur_req) begin
          w_nxt_st = StLoad;
          w_acc    = 1'b1;
        end
      end
      StLoad: begin
        if (w_cur_cnt == LastLoad) begin
          w_nxt_st  = StRound;
          w_nxt_cnt = '0;
        end
      end
      StRound: begin
        if (w_cur_cnt == LastRound) begin
          w_nxt_st  = StDrain;
          w_nxt_cnt = '0;
        end
      end
      StDrain: begin
        if (w_cur_cnt == LastLoad) begin
          w_nxt_cnt = '0;
          w_fin     = 1'b1;
          w_acc     = w_cur_req;
          w_nxt_st  = w_cur_req ? StLoad : StIdle;
        end
      end
      default: begin
        w_nxt_st  = StIdle;
        w_nxt_cnt = '0;
      end
    endcase
  end

  // Decode the thread owning the next cycle; its state is stable across this edge.
  always_comb begin
    w_oth_st  = r_tid ? r_st0 : r_st1;
    w_oth_cnt = r_tid ? r_cnt0 : r_cnt1;
    w_strb    = '0;
    unique case (w_oth_st)
      StLoad: begin
        w_strb.b2c     = 1'b1;
        w_strb.ld_addr = w_oth_cnt[2:0];
        w_strb.t1_rst  = 1'b1;
        if (w_oth_cnt < 7'd6) begin
          w_strb.s1_rst = 1'b1;
          w_strb.s0_rst = 1'b1;
        end else begin
          w_strb.s1_en = 1'b1;
          w_strb.s0_en = 1'b1;
        end
        w_strb.d2e  = (w_oth_cnt >= 7'd4);
        w_strb.d2e2 = (w_oth_cnt >= 7'd4);
      end
      StRound: begin
        w_strb.rnd   = w_oth_cnt;
        w_strb.s1_en = 1'b1;
        w_strb.s0_en = 1'b1;
        w_strb.d2e2  = (w_oth_cnt == 7'd0);
      end
      StDrain: begin
        w_strb.out_en   = 1'b1;
        w_strb.out_addr = w_oth_cnt[2:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_tid  <= 1'b0;
      r_st0  <= StIdle;
      r_st1  <= StIdle;
      r_cnt0 <= '0;
      r_cnt1 <= '0;
      r_ack  <= '0;
      r_done <= '0;
      r_strb <= '0;
    end else if (en) begin
      r_tid  <= ~r_tid;
      r_ack  <= {r_tid & w_acc, ~r_tid & w_acc};
      r_done <= {r_tid & w_fin, ~r_tid & w_fin};
      r_strb <= w_strb;
      if (r_tid) begin
        r_st1  <= w_nxt_st;
        r_cnt1 <= w_nxt_cnt;
      end else begin
        r_st0  <= w_nxt_st;
        r_cnt0 <= w_nxt_cnt;
      end
    end
  end

  assign ack          = r_ack;
  assign done         = r_done;
  assign ready        = {r_st1 == StIdle, r_st0 == StIdle};
  assign tid          = r_tid;
  assign glbl_en      = en;
  assign block2ctx_en = r_strb.b2c;
  assign ld_addr      = r_strb.ld_addr;
  assign T1_rst       = r_strb.t1_rst;
  assign S1_CH_rst    = r_strb.s1_rst;
  assign S0_rst       = r_strb.s0_rst;
  assign S1_CH_en     = r_strb.s1_en;
  assign S0_en        = r_strb.s0_en;
  assign D2E_en       = r_strb.d2e;
  assign D2E_en2      = r_strb.d2e2;
  assign rnd          = r_strb.rnd;
  assign out_en       = r_strb.out_en;
  assign out_addr     = r_strb.out_addr;

endmodule

// File: tb/tb_sha512_ctx_sched.sv
// Bench for sha512_ctx_sched: slot-position reference model, LOAD decode table and a
// done-time scoreboard, driven through single, dual, chained, stalled and aborted blocks.
module tb_sha512_ctx_sched;

  localparam int ROUNDS = 80;
  localparam int BLK    = 8 + ROUNDS + 8;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] ack, ready, done;
  logic       tid, glbl_en, block2ctx_en, T1_rst, S1_CH_rst, S0_rst, S1_CH_en, S0_en;
  logic       D2E_en, D2E_en2, out_en;
  logic [2:0] ld_addr, out_addr;
  logic [6:0] rnd;

  always #5 CLK = ~CLK;

  sha512_ctx_sched #(.ROUNDS(ROUNDS), .LOAD_WORDS(8)) dut (
    .CLK(CLK), .rst_n(rst_n), .en(en), .req(req), .ack(ack), .ready(ready), .tid(tid),
    .glbl_en(glbl_en), .block2ctx_en(block2ctx_en), .ld_addr(ld_addr), .T1_rst(T1_rst),
    .S1_CH_rst(S1_CH_rst), .S0_rst(S0_rst), .S1_CH_en(S1_CH_en), .S0_en(S0_en),
    .D2E_en(D2E_en), .D2E_en2(D2E_en2), .rnd(rnd), .out_en(out_en), .out_addr(out_addr),
    .done(done)
  );

  typedef struct packed {
    logic b2c; logic [2:0] ld; logic t1r, s1r, s0r, s1e, s0e, d2e, d2e2;
    logic [6:0] rnd; logic oe; logic [2:0] oa;
  } strb_t;
  typedef struct { int pos; strb_t exp; } vec_t;
  typedef struct { int thr; int cyc; } ev_t;

  vec_t  load_tab [8];
  ev_t   done_q [$];
  int    n_cmp = 0, n_bad = 0, cyc = 0;
  int    rcnt [2];
  logic [1:0] d_prev = 2'b00;

  logic [21:0] strb_vec;
  logic [29:0] dut_vec;
  assign strb_vec = {block2ctx_en, ld_addr, T1_rst, S1_CH_rst, S0_rst, S1_CH_en, S0_en,
                     D2E_en, D2E_en2, rnd, out_en, out_addr};
  assign dut_vec  = {ack, ready, tid, glbl_en, strb_vec, done};

  // Reference model: per-thread slot position in the block (-1 idle, 0..BLK-1).
  int         m_pos [2];
  logic       m_tid;
  logic [1:0] m_ack, m_done;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      m_tid <= 1'b0; m_pos[0] <= -1; m_pos[1] <= -1; m_ack <= 2'b00; m_done <= 2'b00;
    end else if (en) begin
      m_ack  <= 2'b00;
      m_done <= 2'b00;
      m_tid  <= ~m_tid;
      if (m_pos[m_tid] < 0) begin
        if (req[m_tid]) begin
          m_pos[m_tid] <= 0;
          m_ack[m_tid] <= 1'b1;
        end
      end else if (m_pos[m_tid] == BLK - 1) begin
        m_done[m_tid] <= 1'b1;
        m_ack[m_tid]  <= req[m_tid];
        m_pos[m_tid]  <= req[m_tid] ? 0 : -1;
      end else begin
        m_pos[m_tid] <= m_pos[m_tid] + 1;
      end
    end
  end

  function automatic strb_t mk(input logic b2c, input logic [2:0] ld, input logic t1r,
                               input logic clr, input logic ena, input logic d2,
                               input logic d2b, input logic [6:0] r, input logic oe,
                               input logic [2:0] oa);
    strb_t s;
    s.b2c = b2c; s.ld = ld; s.t1r = t1r; s.s1r = clr; s.s0r = clr; s.s1e = ena; s.s0e = ena;
    s.d2e = d2; s.d2e2 = d2b; s.rnd = r; s.oe = oe; s.oa = oa;
    return s;
  endfunction

  function automatic strb_t dec(input int pos);
    if (pos < 0) return '0;
    if (pos < 8) return load_tab[pos].exp;
    if (pos < 8 + ROUNDS) return mk(0, 0, 0, 0, 1, 0, pos == 8, 7'(pos - 8), 0, 0);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'(pos - 8 - ROUNDS));
  endfunction

  function automatic logic [29:0] exp_vec();
    logic [1:0] rdy;
    rdy = {m_pos[1] < 0, m_pos[0] < 0};
    return {m_ack, rdy, m_tid, en, dec(m_pos[m_tid]), m_done};
  endfunction

  task automatic chk(input string name, input logic [29:0] act, input logic [29:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle_check();
    int idx;
    chk("outputs", dut_vec, exp_vec());
    chk("clr_en_excl", {S0_rst & S0_en, S1_CH_rst & S1_CH_en}, 30'd0);
    if (en && rst_n && S1_CH_en && !block2ctx_en) rcnt[tid]++;
    for (int t = 0; t < 2; t++) begin
      if (done[t] && !d_prev[t]) begin
        idx = -1;
        for (int i = 0; i < done_q.size(); i++)
          if (idx < 0 && done_q[i].thr == t) idx = i;
        if (idx < 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected thread %0d @cyc %0d: got pulse, want none", t, cyc);
        end else begin
          chk("done_cycle", 30'(cyc), 30'(done_q[idx].cyc));
          done_q.delete(idx);
        end
      end
    end
    d_prev = done;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      cycle_check();
      #1;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic wait_slot0();
    if (m_tid) step(1);
  endtask

  int a, b, r0, r1;

  initial begin
    load_tab[0] = '{0, mk(1, 3'd0, 1, 1, 0, 0, 0, 0, 0, 0)};
    load_tab[1] = '{1, mk(1, 3'd1, 1, 1, 0, 0, 0, 0, 0, 0)};
    load_tab[2] = '{2, mk(1, 3'd2, 1, 1, 0, 0, 0, 0, 0, 0)};
    load_tab[3] = '{3, mk(1, 3'd3, 1, 1, 0, 0, 0, 0, 0, 0)};
    load_tab[4] = '{4, mk(1, 3'd4, 1, 1, 0, 1, 1, 0, 0, 0)};
    load_tab[5] = '{5, mk(1, 3'd5, 1, 1, 0, 1, 1, 0, 0, 0)};
    load_tab[6] = '{6, mk(1, 3'd6, 1, 0, 1, 1, 1, 0, 0, 0)};
    load_tab[7] = '{7, mk(1, 3'd7, 1, 0, 1, 1, 1, 0, 0, 0)};
    rcnt[0] = 0; rcnt[1] = 0;

    #1 rst_n = 1'b0;
    step(2);
    chk("reset_state", dut_vec, {2'b00, 2'b11, 1'b0, 1'b0, 22'd0, 2'b00});

    // Single thread
    rst_n = 1'b1; en = 1'b1; req = 2'b01; a = cyc; r0 = rcnt[0];
    done_q.push_back('{0, a + 1 + 2 * BLK});
    step(1); req = 2'b00;
    chk("ack0_latency", 30'(ack), 30'd1);
    wait_cyc(a + 200);
    chk("rounds_t0", 30'(rcnt[0] - r0), 30'(ROUNDS));
    chk("ready_back", 30'(ready), 30'd3);

    // Dual interleave from reset
    rst_n = 1'b0; step(1);
    rst_n = 1'b1; req = 2'b11; a = cyc; r0 = rcnt[0]; r1 = rcnt[1];
    done_q.push_back('{0, a + 1 + 2 * BLK});
    done_q.push_back('{1, a + 2 + 2 * BLK});
    step(2); req = 2'b00;
    wait_cyc(a + 200);
    chk("dual_rounds_t0", 30'(rcnt[0] - r0), 30'(ROUNDS));
    chk("dual_rounds_t1", 30'(rcnt[1] - r1), 30'(ROUNDS));

    // Chaining with req[0] held
    wait_slot0();
    req = 2'b01; a = cyc;
    done_q.push_back('{0, a + 1 + 2 * BLK});
    done_q.push_back('{0, a + 1 + 4 * BLK});
    wait_cyc(a + 1 + 2 * BLK);
    chk("chain_ack_done", {ack[0], done[0]}, 30'd3);
    chk("chain_ready0", 30'(ready[0]), 30'd0);
    wait_cyc(a + 2 + 2 * BLK);
    chk("chain_load0", {block2ctx_en, ld_addr}, {26'd0, 1'b1, 3'd0});
    wait_cyc(a + 250); req = 2'b00;
    wait_cyc(a + 8 + 4 * BLK);
    chk("chain_idle", 30'(ready), 30'd3);

    // Stall at round 37
    wait_slot0();
    req = 2'b01; a = cyc;
    done_q.push_back('{0, a + 1 + 2 * BLK + 5});
    step(1); req = 2'b00;
    wait_cyc(a + 2 + 2 * (8 + 37));
    chk("stall_at37", {tid, rnd}, {1'b0, 7'd37});
    en = 1'b0;
    step(5);
    chk("stall_resume", {tid, rnd}, {1'b0, 7'd37});
    en = 1'b1;
    wait_cyc(a + 210);

    // Reset abort at round 50, then restart and LOAD decode table
    wait_slot0();
    req = 2'b01; a = cyc;
    step(1); req = 2'b00;
    wait_cyc(a + 2 + 2 * (8 + 50));
    chk("abort_at50", {tid, rnd}, {1'b0, 7'd50});
    rst_n = 1'b0;
    #1 chk("abort_clear", dut_vec, {2'b00, 2'b11, 1'b0, 1'b1, 22'd0, 2'b00});
    step(1); rst_n = 1'b1;
    step(200);
    wait_slot0();
    req = 2'b01; b = cyc;
    done_q.push_back('{0, b + 1 + 2 * BLK});
    step(1); req = 2'b00;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(b + 2 + 2 * load_tab[i].pos);
      chk("load_decode", 30'(strb_vec), 30'(load_tab[i].exp));
    end
    wait_cyc(b + 18);
    chk("round0_decode", 30'(strb_vec), 30'(mk(0, 0, 0, 0, 1, 0, 1, 7'd0, 0, 0)));
    wait_cyc(b + 20);
    chk("round1_decode", 30'(strb_vec), 30'(mk(0, 0, 0, 0, 1, 0, 0, 7'd1, 0, 0)));
    wait_cyc(b + 200);

    chk("scoreboard_empty", 30'(done_q.size()), 30'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
